// File: rtl/cdr_pkg.sv
// Shared CDR types: PFD state encoding and one-sided length counter width.
// Latency: n/a (package only).
// Backpressure: n/a.
package cdr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DN   = 2'd2,
      BOTH = 2'd3
   } pfd_state_t;

   localparam int PFD_LEN_W = 16;

endpackage

// File: rtl/pfd_edge_sync.sv
// Synchronises an asynchronous clock-like input into clk and flags its rising edges.
// Latency: rise asserts combinationally SYNC_STAGES clk edges after d is first sampled high.
// Backpressure: none; every synchronised 0->1 transition produces a one-cycle rise.
//
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset, clears synchroniser and delay flops
//   d     - asynchronous input
//   rise  - one-cycle pulse on a synchronised rising edge of d
module pfd_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_dly;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_dly  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], d};
         r_dly  <= r_sync[SYNC_STAGES-1];
      end
   end

   assign rise = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/pfd_sampled.sv
// Oversampled tri-state phase-frequency detector driving charge-pump up/down enables.
// Latency: up/down rise SYNC_STAGES+1 clk edges after the input is first sampled high.
// Backpressure: none; edges arriving while the FSM cannot use them are dropped.
//
// Ports:
//   clk    - sampling clock (>= 8x reference)
//   rst_n  - asynchronous active-low reset
//   ref_in - reference clock, asynchronous to clk
//   fb_in  - feedback (divided VCO) clock, asynchronous to clk
//   up     - charge-pump source enable, registered
//   down   - charge-pump sink enable, registered
//   locked - lock indication, registered; only present when PFD_LOCK_DET_EN is defined
//
// Build option: define PFD_LOCK_DET_EN to add the lock detector and the locked port.
module pfd_sampled
   import cdr_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_PULSE   = 2,
   parameter int LOCK_WIN    = 1,
   parameter int LOCK_CNT    = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ref_in,
   input  logic fb_in,
   output logic up,
   output logic down
`ifdef PFD_LOCK_DET_EN
   ,
   output logic locked
`endif
);

   localparam int BOTH_W = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;

   logic              w_ref_rise;
   logic              w_fb_rise;
   pfd_state_t        r_state;
   pfd_state_t        w_state_nxt;
   logic [BOTH_W-1:0] r_both_cnt;
   logic              w_both_exit;

   pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ref_in),
      .rise  (w_ref_rise)
   );

   pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (fb_in),
      .rise  (w_fb_rise)
   );

   assign w_both_exit = (r_state == BOTH) && (r_both_cnt == '0);

   // Same-side edges are ignored in UP/DN so a frequency error saturates the
   // pump in one direction; everything is ignored while in BOTH.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_ref_rise && w_fb_rise) w_state_nxt = BOTH;
            else if (w_ref_rise)         w_state_nxt = UP;
            else if (w_fb_rise)          w_state_nxt = DN;
         end
         UP:      if (w_fb_rise)  w_state_nxt = BOTH;
         DN:      if (w_ref_rise) w_state_nxt = BOTH;
         BOTH:    if (w_both_exit) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs decode the next state so they change on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_both_cnt <= '0;
         up         <= 1'b0;
         down       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         up      <= (w_state_nxt == UP) || (w_state_nxt == BOTH);
         down    <= (w_state_nxt == DN) || (w_state_nxt == BOTH);
         if ((w_state_nxt == BOTH) && (r_state != BOTH))
            r_both_cnt <= BOTH_W'(MIN_PULSE - 1);
         else if ((r_state == BOTH) && (r_both_cnt != '0))
            r_both_cnt <= r_both_cnt - BOTH_W'(1);
      end
   end

`ifdef PFD_LOCK_DET_EN
   localparam int LOCK_W = $clog2(LOCK_CNT + 1);

   logic [PFD_LEN_W-1:0] r_len;
   logic [LOCK_W-1:0]    r_lock_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len      <= '0;
         r_lock_cnt <= '0;
         locked     <= 1'b0;
      end else begin
         // Any exit from IDLE starts a new comparison; a direct IDLE->BOTH
         // entry therefore leaves a length of 0.
         if ((r_state == IDLE) && (w_state_nxt != IDLE))
            r_len <= '0;
         else if (((r_state == UP) || (r_state == DN)) && (r_len != '1))
            r_len <= r_len + PFD_LEN_W'(1);

         if (w_both_exit) begin
            if (r_len <= PFD_LEN_W'(LOCK_WIN)) begin
               if (r_lock_cnt != LOCK_W'(LOCK_CNT))
                  r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
            end else begin
               r_lock_cnt <= '0;
            end
         end

         locked <= (r_lock_cnt == LOCK_W'(LOCK_CNT));
      end
   end
`endif

endmodule

// File: tb/tb_pfd_sampled.sv
// Scoreboard bench for pfd_sampled: stimulus pushes expected pulse shapes, a monitor measures them.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_pfd_sampled;

   localparam int SYNC_STAGES = 2;
   localparam int MIN_PULSE   = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic ref_in;
   logic fb_in;
   logic up;
   logic down;
`ifdef PFD_LOCK_DET_EN
   logic locked;
`endif

   int checks   = 0;
   int failures = 0;
   int last_first_up;

   typedef struct {
      int ulen;
      int dlen;
      int off;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   pfd_sampled #(
      .SYNC_STAGES (SYNC_STAGES),
      .MIN_PULSE   (MIN_PULSE),
      .LOCK_WIN    (1),
      .LOCK_CNT    (16)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ref_in (ref_in),
      .fb_in  (fb_in),
      .up     (up),
      .down   (down)
`ifdef PFD_LOCK_DET_EN
      ,
      .locked (locked)
`endif
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: measures each up/down activity window and checks it against the queue.
   logic m_act = 1'b0;
   int   m_cyc = 0;
   int   m_ul, m_dl, m_us, m_ds, m_ue, m_de;
   exp_t m_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_act = 1'b0;
      end else begin
         m_cyc++;
         if (up || down) begin
            if (!m_act) begin
               m_act = 1'b1;
               m_ul = 0; m_dl = 0;
               m_us = -1; m_ds = -1; m_ue = -1; m_de = -1;
            end
            if (up) begin
               m_ul++;
               if (m_us < 0) m_us = m_cyc;
               m_ue = m_cyc;
            end
            if (down) begin
               m_dl++;
               if (m_ds < 0) m_ds = m_cyc;
               m_de = m_cyc;
            end
         end else if (m_act) begin
            m_act = 1'b0;
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               m_e = exp_q.pop_front();
               chk("up_len",      m_ul,        m_e.ulen);
               chk("down_len",    m_dl,        m_e.dlen);
               chk("down_offset", m_ds - m_us, m_e.off);
               chk("fall_skew",   m_ue - m_de, 0);
            end
         end
      end
   end

   function automatic logic [63:0] pmask(input int at);
      logic [63:0] m = '0;
      for (int i = 0; i < 4; i++) m[at+i] = 1'b1;
      return m;
   endfunction

   // Bit c of each mask is the input level for cycle c; inputs change 2 ns after posedge.
   task automatic run_wave(input logic [63:0] rw, input logic [63:0] fw, input int n,
                           output int first_up);
      first_up = -1;
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         if (up && first_up < 0) first_up = c;
         #1;
         ref_in = rw[c];
         fb_in  = fw[c];
      end
   endtask

   task automatic pair(input int rat, input int fat, input int eu, input int ed, input int eoff);
      exp_t e;
      int   fu;
      e.ulen = eu; e.dlen = ed; e.off = eoff;
      exp_q.push_back(e);
      run_wave(pmask(rat), pmask(fat), 24, fu);
      last_first_up = fu;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int fu;
      rst_n  = 1'b0;
      ref_in = 1'b0;
      fb_in  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_up",   int'(up),   0);
      chk("reset_down", int'(down), 0);
`ifdef PFD_LOCK_DET_EN
      chk("reset_locked", int'(locked), 0);
`endif
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("idle_up",   int'(up),   0);
      chk("idle_down", int'(down), 0);

      // Ref leads fb by 5: up 7, down 2 starting 5 later; up appears 3 edges after sampling.
      pair(0, 5, 7, 2, 5);
      chk("up_latency", last_first_up, SYNC_STAGES + 1);

      // Fb leads ref by 3.
      pair(3, 0, 2, 5, -3);

      // Coincident edges.
      pair(0, 0, 2, 2, 0);

      // Ref at twice the fb rate: extra ref edges at 10 and 20 are ignored.
      begin
         exp_t e;
         e.ulen = 27; e.dlen = 2; e.off = 25;
         exp_q.push_back(e);
         run_wave(pmask(0) | pmask(10) | pmask(20), pmask(25), 40, fu);
      end

      // Asynchronous reset in the middle of UP.
      run_wave(pmask(0), '0, 5, fu);
      chk("up_before_reset", int'(up), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("up_async_reset",   int'(up),   0);
      chk("down_async_reset", int'(down), 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      run_wave('0, '0, 6, fu);
      chk("post_reset_up",   int'(up),   0);
      chk("post_reset_down", int'(down), 0);
      // A lone fb lead after reset must produce a DN pulse, proving the FSM is back in IDLE.
      pair(3, 0, 2, 5, -3);

`ifdef PFD_LOCK_DET_EN
      for (int k = 0; k < 15; k++) pair(0, 0, 2, 2, 0);
      chk("locked_after_15", int'(locked), 0);
      begin
         exp_t e;
         e.ulen = 2; e.dlen = 2; e.off = 0;
         exp_q.push_back(e);
         run_wave(pmask(0), pmask(0), 6, fu);
      end
      chk("locked_at_16th_exit", int'(locked), 0);
      @(posedge clk);
      #1;
      chk("locked_after_16th", int'(locked), 1);
      run_wave('0, '0, 10, fu);
      chk("locked_hold", int'(locked), 1);
      pair(0, 4, 6, 2, 4);
      chk("locked_after_lead", int'(locked), 0);
`endif

      run_wave('0, '0, 10, fu);
      chk("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pfd_sampled.md
# pfd_sampled

Oversampled tri-state phase-frequency detector for the CDR loop. It samples the reference and feedback (divided VCO) clocks on a fast system clock and detects their rising edges. It drives `up`/`down` pulses straight into the charge-pump stage. A fixed reset-delay keeps both outputs high for a minimum time, which removes the dead zone. An optional lock detector is included.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per input (≥2).
- `MIN_PULSE`, 2: cycles both outputs stay high in BOTH (≥1).
- `LOCK_WIN`, 1: maximum one-sided pulse length, in cycles, counted as in-lock.
- `LOCK_CNT`, 16: consecutive in-lock comparisons required to assert `locked`.
- `clk` in 1: sampling clock, ≥8× reference frequency.
- `rst_n` in 1: asynchronous, active-low reset.
- `ref_in` in 1: reference clock, asynchronous to `clk`.
- `fb_in` in 1: feedback clock, asynchronous to `clk`.
- `up` out 1: charge-pump source enable; registered.
- `down` out 1: charge-pump sink enable; registered.
- `locked` out 1: lock indication; present only with `PFD_LOCK_DET_EN`.

## Operation
- Each input passes through `SYNC_STAGES` flops plus one delay flop. Rising edge = synced high AND delayed low.
- States: IDLE, UP, DN, BOTH. Outputs decode from the next state and are registered:
  - `up` = UP|BOTH
  - `down` = DN|BOTH
- IDLE:
  - ref_rise & fb_rise → BOTH
  - ref_rise only → UP
  - fb_rise only → DN
  - no edge → stay.
- UP: fb_rise → BOTH. Any ref_rise is ignored, so a frequency error saturates high.
- DN: ref_rise → BOTH. Any fb_rise is ignored.
- BOTH:
  - Down-counter loads `MIN_PULSE-1` on entry and exits to IDLE when it reaches 0.
  - All edges arriving in BOTH are discarded.
- One-sided length counter: 16 bits, saturating. Cleared on entry to UP/DN, increments each cycle in UP/DN.
- Reset, asserted at any time: immediately forces IDLE, all sync/delay flops to 0, `up`=`down`=0, lock counter 0, `locked`=0.
- After reset release, an input already high appears as a rising edge once it passes the synchronizer. This is the intended behaviour.

## Timing
- Latency: `up` (`down`) rises `SYNC_STAGES`+1 `clk` edges after the first edge that samples `ref_in` (`fb_in`) high.
- Ref leads fb by N synced cycles (N≥1):
  - `up` high for N+`MIN_PULSE` cycles.
  - `down` high for `MIN_PULSE` cycles, starting N cycles after `up`.
  - Both fall on the same edge.
- Coincident edges: both outputs high for exactly `MIN_PULSE` cycles.
- Minimum period between accepted edges of the same input is `MIN_PULSE`+1 cycles. Faster inputs lose edges by design.

## Configuration
- `PFD_LOCK_DET_EN` defined:
  - Every BOTH→IDLE transition evaluates the last one-sided length; coincident entry counts as length 0.
  - Length ≤ `LOCK_WIN`: the lock counter increments, saturating at `LOCK_CNT`.
  - Otherwise: the counter clears and `locked` drops on the next edge.
  - `locked` = (counter == `LOCK_CNT`), registered; it asserts one cycle after the qualifying transition.
- `PFD_LOCK_DET_EN` undefined: no `locked` port, no lock counter. The up/down behaviour is identical.

## Structure
- Shared package `cdr_pkg`: typedef enum `pfd_state_t` {IDLE, UP, DN, BOTH}; localparam `PFD_LEN_W` = 16.
- Sub-module `pfd_edge_sync`: parameter `SYNC_STAGES`; ports clk, rst_n, d, rise. Instantiated once for `ref_in` and once for `fb_in`.
- The top holds the FSM, the BOTH counter, the length counter and the lock logic.

## Test plan
- Reset and release with `ref_in`=`fb_in`=0 → `up`=`down`=0; with `locked` enabled, `locked`=0.
- Ref leads fb by 5 cycles, defaults → `up` high 7 cycles, `down` high 2 cycles, both fall together; first `up` edge 3 cycles after ref sampled high.
- Fb leads ref by 3 cycles → `down` high 5 cycles, `up` high 2 cycles.
- Ref at 2× fb frequency → `up` stays high through the extra ref edges; `down` never exceeds `MIN_PULSE` cycles.
- `rst_n` pulsed low mid-UP → `up` drops asynchronously without waiting for `clk`; state returns to IDLE.
- With `PFD_LOCK_DET_EN`: 16 consecutive coincident edge pairs → `locked`=1 one cycle after the 16th BOTH exit. Then a 4-cycle lead → `locked`=0.
